div_unit: RTL

- Multi-cycle 32-bit signed/unsigned integer divider with its sequencing FSM.
- Serves the EX stage's DIV/DIVU handshake; EX drives start/operands and stalls until ready.
- Sits beside EX at pipeline top level; `{remainder, quotient}` goes back to EX for the HI/LO write.
- annul_i, driven from pipeline flush logic, cancels an in-flight divide.

---
 rtl/div_unit_pkg.sv | 25 ++
 rtl/div_step.sv | 39 +++
 rtl/div_unit.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// ---------------------------------------------------------------------------
// div_unit_pkg
// Shared definitions for the multi-cycle integer divider: FSM state
// encodings, handshake level names and the default operand width.
// ---------------------------------------------------------------------------
package div_unit_pkg;

    // Default operand width; the iteration count equals this width.
    localparam int DIV_DATA_W = 32;

    // Divider sequencing states (2-bit encoding).
    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    // Handshake levels seen on ready_o / start_i.
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration.
//
// Ports:
//   work      in  [2*DATA_W:0]  work register: partial remainder in the upper
//                               half, remaining dividend / quotient bits below
//   divisor   in  [DATA_W-1:0]  divisor magnitude
//   work_next out [2*DATA_W:0]  work register after this iteration
// ---------------------------------------------------------------------------
module div_step
    import div_unit_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic [2*DATA_W:0]  work,
    input  logic [DATA_W-1:0]  divisor,
    output logic [2*DATA_W:0]  work_next
);

    logic              fits;
    logic [DATA_W-1:0] rem_sub;

    // The partial remainder window is DATA_W+1 bits wide, because a
    // remainder just below a large divisor shifted left by one overflows
    // DATA_W bits. When the subtraction succeeds the true difference is
    // below the divisor, so the low DATA_W bits of the modular difference
    // are exact.
    assign fits    = work[2*DATA_W:DATA_W] >= {1'b0, divisor};
    assign rem_sub = work[2*DATA_W-1:DATA_W] - divisor;

    always_comb begin
        work_next = {work[2*DATA_W-1:0], 1'b0};
        if (fits) begin
            work_next = {rem_sub, work[DATA_W-1:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
// Multi-cycle signed/unsigned integer divider for the EX stage DIV/DIVU
// handshake. One restoring step per cycle, DATA_W steps per divide.
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   asynchronous reset, active low
//   signed_div_i  in   1 = signed divide, 0 = unsigned (sampled at accept)
//   opdata1_i     in   dividend (sampled at accept)
//   opdata2_i     in   divisor  (sampled at accept)
//   start_i       in   request, held high by EX until it sees ready_o
//   annul_i       in   cancel current operation (priority over start_i)
//   result_o      out  {remainder, quotient}
//   ready_o       out  result valid
// ---------------------------------------------------------------------------
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);

    localparam int                CNT_W     = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(DATA_W - 1);

    function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v,
                                                 input logic              en);
        return en ? (~v + {{(DATA_W-1){1'b0}}, 1'b1}) : v;
    endfunction

    div_state_e        state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              s1, s2, sign_mode;
    logic [DATA_W-1:0] divisor;
    logic [2*DATA_W:0] work, work_nxt;

    logic              go;
    logic              s1_in, s2_in;
    logic [DATA_W-1:0] quot_fix, rem_fix;

    assign go    = (start_i == DIV_START) && !annul_i;
    assign s1_in = signed_div_i & opdata1_i[DATA_W-1];
    assign s2_in = signed_div_i & opdata2_i[DATA_W-1];

    div_step #(.DATA_W(DATA_W)) u_step (
        .work      (work),
        .divisor   (divisor),
        .work_next (work_nxt)
    );

    // Sign fixup applied to the result of the final step: quotient
    // truncates toward zero, remainder follows the dividend's sign.
    assign quot_fix = neg_if(work_nxt[DATA_W-1:0],         sign_mode & (s1 ^ s2));
    assign rem_fix  = neg_if(work_nxt[2*DATA_W:DATA_W+1],  sign_mode & s1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= DIV_FREE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            DIV_FREE: begin
                if (go) begin
                    state_nxt = (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
                end
            end
            DIV_BYZERO: begin
                state_nxt = annul_i ? DIV_FREE : DIV_END;
            end
            DIV_ON: begin
                if (!go) begin
                    state_nxt = DIV_FREE;
                end else if (cnt == LAST_STEP) begin
                    state_nxt = DIV_END;
                end
            end
            DIV_END: begin
                if (!go) begin
                    state_nxt = DIV_FREE;
                end
            end
            default: state_nxt = DIV_FREE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            s1        <= 1'b0;
            s2        <= 1'b0;
            sign_mode <= 1'b0;
            divisor   <= '0;
            work      <= '0;
            result_o  <= '0;
            ready_o   <= DIV_RESULT_NOT_READY;
        end else begin
            case (state)
                DIV_FREE: begin
                    ready_o  <= DIV_RESULT_NOT_READY;
                    result_o <= '0;
                    if (go) begin
                        s1        <= s1_in;
                        s2        <= s2_in;
                        sign_mode <= signed_div_i;
                        divisor   <= neg_if(opdata2_i, s2_in);
                        // Dividend sits at [DATA_W:1] so the first step
                        // already sees its MSB in the remainder window.
                        work      <= {{DATA_W{1'b0}}, neg_if(opdata1_i, s1_in), 1'b0};
                        cnt       <= '0;
                    end
                end
                DIV_BYZERO: begin
                    ready_o  <= DIV_RESULT_NOT_READY;
                    result_o <= '0;
                end
                DIV_ON: begin
                    if (!go) begin
                        ready_o  <= DIV_RESULT_NOT_READY;
                        result_o <= '0;
                        cnt      <= '0;
                    end else begin
                        work <= work_nxt;
                        cnt  <= cnt + 1'b1;
                        if (cnt == LAST_STEP) begin
                            result_o <= {rem_fix, quot_fix};
                            ready_o  <= DIV_RESULT_READY;
                        end
                    end
                end
                DIV_END: begin
                    // A zero-divisor divide enters END with ready low and
                    // raises it here, one edge later; a normal divide
                    // arrives with ready already high and simply holds it.
                    if (!go) begin
                        ready_o  <= DIV_RESULT_NOT_READY;
                        result_o <= '0;
                    end else begin
                        ready_o  <= DIV_RESULT_READY;
                    end
                end
                default: begin
                    ready_o  <= DIV_RESULT_NOT_READY;
                    result_o <= '0;
                end
            endcase
        end
    end

endmodule
